sdram_vga_fetch: RTL and testbench
==================================

// Module: sdram_vga_fetch
// PURPOSE
//  Video-side prefetcher for the SDRAM controller's VGA read port. Issues rdvga
//  burst requests (8 words each) at sequential 8-aligned addresses in a frame
//  buffer and captures the returned words into a FIFO. The pixel pipeline pops
//  16-bit words from that FIFO at its own pace. Sits between the SDRAM
//  controller (addrvga/rdvga/doutvga/readyvga) and the video timing/pixel
//  shifter.
// PARAMETERS
//  FIFO_DEPTH  32  FIFO capacity in words; power of 2, >= 16
//  BURST_WORDS  8  words returned per rdvga request; fixed by the SDRAM
//                  controller mode register
// PORTS
//  clk          in   1   system clock, same clock as the SDRAM controller
//  reset_n      in   1   asynchronous active-low reset
//  init_ok      in   1   SDRAM initialised; no request is issued while 0
//  frame_base   in  24   word address of frame start; bits [2:0] are ignored (forced 0)
//  frame_words  in  24   frame length in words; multiple of 8, nonzero
//  frame_start  in   1   1-cycle pulse: restart fetch at frame_base, flush FIFO
//  addrvga      out 24   burst start address to the controller; [2:0] always 0
//  rdvga        out  1   read request; the controller acts on its rising edge
//  doutvga      in  16   read data from the controller
//  readyvga     in   1   doutvga valid this cycle (8 pulses per burst)
//  pix_rd       in   1   pop one word from the FIFO
//  pix_data     out 16   FIFO head word (first-word-fall-through)
//  pix_valid    out  1   FIFO not empty
//  fifo_level   out $clog2(FIFO_DEPTH)+1  words currently held
//  underflow    out  1   sticky: pix_rd while FIFO empty; cleared by frame_start
// BEHAVIOUR
//  Reset values: rdvga=0, addrvga=0, pix_valid=0, fifo_level=0, underflow=0,
//   pix_data=0. FSM=IDLE. Fetch pointer = 0.
//  FSM (state_t):
//   IDLE  -> REQ when init_ok && fifo_level <= FIFO_DEPTH-BURST_WORDS && !discard.
//         On entry to REQ: addrvga <= frame_base + ptr; rdvga <= 1; word_cnt <= 0.
//   REQ   rdvga held 1. Each readyvga word is pushed (or dropped if discard) and
//         word_cnt increments. When word_cnt reaches 8 -> GAP.
//   GAP   rdvga <= 0 for exactly 1 cycle (a rising edge is required for the
//         next request); ptr <= ptr+8, or 0 if ptr+8 >= frame_words; clear
//         discard; -> IDLE.
//  Space is checked only in IDLE, with nothing outstanding, so a push never
//   overflows. Any readyvga outside REQ is ignored.
//  FIFO: a push and a pop in the same cycle leave the level unchanged.
//   pix_rd while empty: no pop; underflow <= 1. pix_data is held when empty.
//  frame_start (highest priority):
//   - FIFO is flushed (level 0); ptr <= 0; underflow <= 0.
//   - In IDLE/GAP: the next request uses the new base.
//   - In REQ: discard <= 1; the remaining words of the in-flight burst are
//     counted but not pushed; the burst still completes with GAP; the pointer
//     update in GAP is suppressed (ptr stays 0).
//   - A pop in the same cycle is ignored.
//  Address arithmetic: 24-bit unsigned, frame_base + ptr wraps modulo 2^24.
//  Latency: first word reaches pix_valid 1 cycle after its readyvga.
//  reset_n low mid-burst: all state returns to reset values immediately.
//   Late readyvga words are ignored in IDLE.
// STRUCTURE
//  Package sdram_vga_pkg: state_t {IDLE, REQ, GAP}, BURST_WORDS=8, ADDR_W=24,
//   DATA_W=16.
//  Sub-module vga_word_fifo: synchronous FWFT FIFO with push, pop, flush,
//   level, empty; parameter DEPTH. Request FSM, pointer and discard logic live
//   in the top module.
// TESTING
//  1 Reset, init_ok=1, frame_base=0x001000, frame_words=32, model returns 8
//    words 3 cycles after each rdvga rise -> addrvga 0x1000,0x1008,0x1010,
//    0x1018, then 0x1000; rdvga low exactly 1 cycle between requests.
//  2 No pix_rd, FIFO_DEPTH=32 -> after 4 bursts level=32, rdvga stays 0;
//    pop 8 -> a new request is issued.
//  3 pix_rd held every cycle from empty -> underflow=1 and stays 1;
//    frame_start -> underflow=0, level=0.
//  4 frame_start after the 3rd word of a burst -> remaining 5 words dropped,
//    level 0, next addrvga=frame_base.
//  5 Simultaneous push and pop at level 5 -> level stays 5; data order
//    preserved (incrementing pattern checked end-to-end).
//  6 init_ok=0 for 1000 cycles -> rdvga stays 0; reset_n pulse mid-burst ->
//    all outputs return to reset values within 0 cycles (async).

Source files
------------

// File: rtl/sdram_vga_pkg.sv
// Shared types and widths for the SDRAM VGA read-port prefetcher.
package sdram_vga_pkg;

    localparam int unsigned ADDR_W      = 24;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BURST_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

endpackage

// File: rtl/vga_word_fifo.sv
// First-word-fall-through word FIFO with synchronous flush and level output.
module vga_word_fifo #(
    parameter  int unsigned DEPTH = 32,
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LW-1:0]    level_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // hold_q tracks the visible head so the output keeps its last value once empty
    assign rdata_o = empty_o ? hold_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (!empty_o) begin
                hold_q <= mem_q[rd_ptr_q];
            end
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                unique case ({do_push, do_pop})
                    2'b10:   level_q <= level_q + 1'b1;
                    2'b01:   level_q <= level_q - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/sdram_vga_fetch.sv
// VGA prefetcher: issues 8-word rdvga bursts through a frame buffer and
// queues the returned words for the pixel pipeline.
module sdram_vga_fetch
    import sdram_vga_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 32,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init_ok,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W-1:0] frame_words,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] addrvga,
    output logic              rdvga,
    input  logic [DATA_W-1:0] doutvga,
    input  logic              readyvga,
    input  logic              pix_rd,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              underflow
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        word_cnt_q, word_cnt_d;
    logic              rd_q, rd_d;
    logic              discard_q, discard_d;
    logic              uflow_q, uflow_d;
    logic              push;
    logic              fifo_empty;
    logic              space_ok;
    logic              burst_done;
    logic [ADDR_W:0]   ptr_sum;
    logic [ADDR_W-1:0] ptr_eff;
    logic              unused_base_bits;

    assign unused_base_bits = ^frame_base[2:0];

    assign space_ok   = (fifo_level <= LVL_W'(FIFO_DEPTH - BURST_WORDS));
    assign burst_done = (state_q == REQ) && readyvga && (word_cnt_q == 4'(BURST_WORDS - 1));
    assign ptr_sum    = {1'b0, ptr_q} + (ADDR_W + 1)'(BURST_WORDS);
    assign ptr_eff    = frame_start ? '0 : ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (init_ok && space_ok && !discard_q) state_d = REQ;
            REQ:     if (burst_done) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        rd_d       = rd_q;
        word_cnt_d = word_cnt_q;
        ptr_d      = ptr_q;
        discard_d  = discard_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (state_d == REQ) begin
                    addr_d     = {frame_base[ADDR_W-1:3], 3'b000} + ptr_eff;
                    rd_d       = 1'b1;
                    word_cnt_d = '0;
                end
            end
            REQ: begin
                // an aborted burst is still counted to completion, only its data is dropped
                if (readyvga) begin
                    word_cnt_d = word_cnt_q + 4'd1;
                    push       = !discard_q && !frame_start;
                end
                if (frame_start) discard_d = 1'b1;
            end
            GAP: begin
                rd_d      = 1'b0;
                discard_d = 1'b0;
                if (!discard_q) begin
                    ptr_d = (ptr_sum >= {1'b0, frame_words}) ? '0 : ptr_sum[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
        if (frame_start) ptr_d = '0;
        uflow_d = frame_start ? 1'b0 : (uflow_q || (pix_rd && fifo_empty));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            addr_q     <= '0;
            word_cnt_q <= '0;
            rd_q       <= 1'b0;
            discard_q  <= 1'b0;
            uflow_q    <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            rd_q       <= rd_d;
            discard_q  <= discard_d;
            uflow_q    <= uflow_d;
        end
    end

    vga_word_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (doutvga),
        .pop_i   (pix_rd),
        .flush_i (frame_start),
        .rdata_o (pix_data),
        .level_o (fifo_level),
        .empty_o (fifo_empty)
    );

    assign addrvga   = addr_q;
    assign rdvga     = rd_q;
    assign pix_valid = !fifo_empty;
    assign underflow = uflow_q;

endmodule

// File: tb/tb_sdram_vga_fetch.sv
// Randomized bench for sdram_vga_fetch against a queue-based reference model.
module tb_sdram_vga_fetch;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk         = 1'b0;
    logic          reset_n     = 1'b0;
    logic          init_ok     = 1'b0;
    logic [23:0]   frame_base  = 24'h001000;
    logic [23:0]   frame_words = 24'd32;
    logic          frame_start = 1'b0;
    logic [23:0]   addrvga;
    logic          rdvga;
    logic [15:0]   doutvga     = '0;
    logic          readyvga    = 1'b0;
    logic          pix_rd      = 1'b0;
    logic [15:0]   pix_data;
    logic          pix_valid;
    logic [LW-1:0] fifo_level;
    logic          underflow;

    always #5 clk = ~clk;

    sdram_vga_fetch #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .init_ok     (init_ok),
        .frame_base  (frame_base),
        .frame_words (frame_words),
        .frame_start (frame_start),
        .addrvga     (addrvga),
        .rdvga       (rdvga),
        .doutvga     (doutvga),
        .readyvga    (readyvga),
        .pix_rd      (pix_rd),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .fifo_level  (fifo_level),
        .underflow   (underflow)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model: expected FIFO contents and frame pointer
    logic [15:0] exp_q[$];
    logic [23:0] m_ptr    = '0;
    logic [15:0] m_last   = '0;
    bit          m_uflow, m_inflight, m_discard;
    int          words_left, lat_cnt, stale_left;
    int          lat      = 3;
    int          pop_pct  = 0;
    int          gap_pct  = 0;
    int          fs_pct   = 0;
    bit          stray_en, gap_chk, fs_mid, prev_rd;
    int          rises    = 0;
    int          low_run  = 0;
    logic [15:0] word_ctr = 16'h0100;

    task automatic cycle(input bit fs_req);
        bit          fs, rdy, burst_word, pop;
        logic [15:0] w;
        logic [23:0] exp_addr;
        fs         = fs_req || (fs_pct > 0 && int'($urandom_range(999)) < fs_pct);
        rdy        = 1'b0;
        burst_word = 1'b0;
        w          = 16'($urandom);
        if (m_inflight) begin
            if (lat_cnt > 1) lat_cnt--;
            else if (int'($urandom_range(99)) >= gap_pct) begin
                rdy        = 1'b1;
                burst_word = 1'b1;
                w          = word_ctr;
                word_ctr++;
                if (fs_mid && words_left == 5) begin
                    fs     = 1'b1;
                    fs_mid = 1'b0;
                end
            end
        end else if (stale_left > 0) begin
            rdy = 1'b1;
            stale_left--;
        end else if (stray_en && !rdvga && $urandom_range(15) == 0) begin
            rdy = 1'b1;
        end
        pop = int'($urandom_range(99)) < pop_pct;

        if (fs) begin
            exp_q.delete();
            m_ptr   = '0;
            m_uflow = 1'b0;
            if (m_inflight) m_discard = 1'b1;
        end else if (pop) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else m_uflow = 1'b1;
        end
        if (burst_word) begin
            if (!m_discard) exp_q.push_back(w);
            words_left--;
            if (words_left == 0) begin
                m_inflight = 1'b0;
                if (!m_discard) m_ptr = (32'(m_ptr) + 32'd8 >= 32'(frame_words)) ? '0 : m_ptr + 24'd8;
                m_discard = 1'b0;
            end
        end

        frame_start = fs;
        pix_rd      = pop;
        readyvga    = rdy;
        doutvga     = w;
        @(posedge clk);
        #1;
        check_eq("fifo_level", 32'(fifo_level), exp_q.size());
        check_eq("pix_valid", 32'(pix_valid), 32'(exp_q.size() != 0));
        check_eq("underflow", 32'(underflow), 32'(m_uflow));
        if (exp_q.size() > 0) begin
            check_eq("pix_data", 32'(pix_data), 32'(exp_q[0]));
            m_last = exp_q[0];
        end else begin
            check_eq("pix_data_held", 32'(pix_data), 32'(m_last));
        end
        if (rdvga && !prev_rd) begin
            exp_addr = (frame_base & 24'hFFFFF8) + m_ptr;
            check_eq("addrvga", 32'(addrvga), 32'(exp_addr));
            check_eq("req_overlap", 32'(m_inflight), 32'd0);
            if (gap_chk && rises > 0) check_eq("rdvga_low_cycles", low_run, 1);
            rises++;
            m_inflight = 1'b1;
            m_discard  = 1'b0;
            words_left = 8;
            lat_cnt    = lat;
        end
        low_run     = rdvga ? 0 : low_run + 1;
        prev_rd     = rdvga;
        frame_start = 1'b0;
        pix_rd      = 1'b0;
        readyvga    = 1'b0;
    endtask

    initial begin
        int r0;
        #12;
        check_eq("rst_rdvga", 32'(rdvga), 32'd0);
        check_eq("rst_addrvga", 32'(addrvga), 32'd0);
        check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_underflow", 32'(underflow), 32'd0);
        check_eq("rst_pix_data", 32'(pix_data), 32'd0);
        reset_n = 1'b1;

        // back-to-back bursts until full, then one more after popping 8
        init_ok = 1'b1;
        gap_chk = 1'b1;
        for (int i = 0; i < 400 && !(rises == 4 && !m_inflight); i++) cycle(0);
        gap_chk = 1'b0;
        check_eq("four_bursts", rises, 4);
        repeat (40) cycle(0);
        check_eq("full_level", 32'(fifo_level), 32'd32);
        check_eq("full_no_req", rises, 4);
        pop_pct = 100;
        repeat (8) cycle(0);
        pop_pct = 0;
        for (int i = 0; i < 50 && rises < 5; i++) cycle(0);
        check_eq("refill_req", rises, 5);
        check_eq("wrap_addr", 32'(addrvga), 32'h001000);

        // underflow is sticky until frame_start
        for (int i = 0; i < 100 && m_inflight; i++) cycle(0);
        init_ok = 1'b0;
        repeat (3) cycle(0);
        cycle(1);
        pop_pct = 100;
        repeat (20) cycle(0);
        check_eq("underflow_set", 32'(underflow), 32'd1);
        cycle(1);
        check_eq("underflow_clr", 32'(underflow), 32'd0);
        check_eq("flush_level", 32'(fifo_level), 32'd0);
        pop_pct = 0;

        // frame_start after the third word of a burst
        frame_base  = 24'h2A3457;
        frame_words = 24'd64;
        cycle(1);
        init_ok = 1'b1;
        lat     = 2;
        fs_mid  = 1'b1;
        for (int i = 0; i < 100 && fs_mid; i++) cycle(0);
        check_eq("discard_level", 32'(fifo_level), 32'd0);
        r0 = rises;
        for (int i = 0; i < 60 && rises == r0; i++) cycle(0);
        check_eq("restart_addr", 32'(addrvga), 32'h2A3450);

        // randomized traffic
        for (int k = 0; k < 5; k++) begin
            frame_base  = (k == 0) ? 24'hFFFFE3 : 24'($urandom);
            frame_words = 24'(8 * $urandom_range(1, 8));
            pop_pct     = int'($urandom_range(20, 95));
            gap_pct     = int'($urandom_range(0, 40));
            lat         = int'($urandom_range(1, 5));
            fs_pct      = 3;
            stray_en    = 1'b1;
            cycle(1);
            if (k == 2) fs_mid = 1'b1;
            repeat (1500) cycle(0);
        end
        fs_pct   = 0;
        stray_en = 1'b0;
        fs_mid   = 1'b0;
        pop_pct  = 0;
        gap_pct  = 0;
        lat      = 3;

        // no requests without init_ok
        for (int i = 0; i < 100 && m_inflight; i++) cycle(0);
        init_ok = 1'b0;
        repeat (3) cycle(0);
        r0 = rises;
        repeat (1000) cycle(0);
        check_eq("init_low_no_req", rises - r0, 0);

        // asynchronous reset in the middle of a burst
        init_ok = 1'b1;
        pop_pct = 50;
        for (int i = 0; i < 200 && !(m_inflight && words_left <= 6); i++) cycle(0);
        check_eq("mid_burst_reached", 32'(rdvga), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check_eq("arst_rdvga", 32'(rdvga), 32'd0);
        check_eq("arst_addrvga", 32'(addrvga), 32'd0);
        check_eq("arst_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("arst_level", 32'(fifo_level), 32'd0);
        check_eq("arst_underflow", 32'(underflow), 32'd0);
        check_eq("arst_pix_data", 32'(pix_data), 32'd0);
        exp_q.delete();
        stale_left = m_inflight ? words_left : 0;
        m_inflight = 1'b0;
        m_discard  = 1'b0;
        m_ptr      = '0;
        m_uflow    = 1'b0;
        m_last     = '0;
        prev_rd    = 1'b0;
        low_run    = 0;
        init_ok    = 1'b0;
        pop_pct    = 0;
        repeat (3) cycle(0);
        reset_n = 1'b1;
        repeat (6) cycle(0);
        check_eq("stale_ignored", 32'(fifo_level), 32'd0);
        init_ok = 1'b1;
        pop_pct = 50;
        repeat (300) cycle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
